otter_fetch_queue: RTL and testbench



---
 rtl/otter_fetch_queue_pkg.sv | 12 +
 rtl/otter_fetch_queue_if.sv | 26 ++
 rtl/otter_fetch_queue_ptr_ctr.sv | 25 ++
 rtl/otter_fetch_queue.sv | 87 ++++++++
 tb/tb_otter_fetch_queue.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/otter_fetch_queue_pkg.sv
// Shared CPU types for the pipelined OTTER: fetch-queue entry layout and depth limit.
package cpu_types;

  localparam int FQ_MAX_DEPTH = 64;
  localparam int CPU_XLEN     = 32;

  typedef struct packed {
    logic [CPU_XLEN-1:0] pc;
    logic [CPU_XLEN-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/otter_fetch_queue_if.sv
// Fetch/decode handshake bundle around the fetch queue; master = pipeline side, slave = queue.
// Handshake: a transfer happens on a rising edge where VALID and READY are both high;
// VALID never waits on READY, and READY on the fetch side never depends on decode READY.
interface otter_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            IF_VALID;
  logic [XLEN-1:0] IF_PC;
  logic [XLEN-1:0] IF_IR;
  logic            IF_READY;
  logic            ID_VALID;
  logic [XLEN-1:0] ID_PC;
  logic [XLEN-1:0] ID_IR;
  logic            ID_READY;
  logic            FLUSH;

  modport master (
    output IF_VALID, IF_PC, IF_IR, ID_READY, FLUSH,
    input  IF_READY, ID_VALID, ID_PC, ID_IR
  );

  modport slave (
    input  IF_VALID, IF_PC, IF_IR, ID_READY, FLUSH,
    output IF_READY, ID_VALID, ID_PC, ID_IR
  );
endinterface

// File: rtl/otter_fetch_queue_ptr_ctr.sv
// Wrapping pointer counter for the fetch queue; clr wins over inc.
module fq_ptr_ctr #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/otter_fetch_queue.sv
// IF/ID instruction-fetch queue with single-cycle flush.
// Optional same-cycle IF->ID bypass when empty: define OTTER_FQ_BYPASS_EN.
module otter_fetch_queue
  import cpu_types::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  otter_fetch_queue_if.slave         fq,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       OVF_STICKY
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  if (DEPTH < 2 || DEPTH > FQ_MAX_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("otter_fetch_queue: DEPTH must be a power of two in 2..%0d", FQ_MAX_DEPTH);
  end
  if (XLEN != CPU_XLEN) begin : g_bad_xlen
    $error("otter_fetch_queue: XLEN must match cpu_types::CPU_XLEN");
  end

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q;
  logic          full, empty, push, pop, byp, wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

`ifdef OTTER_FQ_BYPASS_EN
  assign byp = empty & fq.IF_VALID & ~fq.FLUSH & RESET_N;
`else
  assign byp = 1'b0;
`endif

  assign fq.IF_READY = ~full & ~fq.FLUSH & RESET_N;
  assign fq.ID_VALID = (~empty & ~fq.FLUSH) | byp;
  assign fq.ID_PC    = byp ? fq.IF_PC : mem_q[rd_ptr].pc;
  assign fq.ID_IR    = byp ? fq.IF_IR : mem_q[rd_ptr].ir;

  assign push  = fq.IF_VALID & fq.IF_READY;
  assign pop   = fq.ID_VALID & fq.ID_READY;
  // A bypassed entry consumed in the same cycle never touches storage.
  assign wr_en = push & ~(byp & fq.ID_READY);
  assign rd_en = pop & ~byp;

  always_comb begin
    count_d = count_q;
    if (fq.FLUSH)            count_d = '0;
    else if (wr_en && !rd_en) count_d = count_q + CW'(1);
    else if (!wr_en && rd_en) count_d = count_q - CW'(1);
  end

  fq_ptr_ctr #(.W(PW)) u_wr_ptr (
    .clk_i (CLK), .rst_ni(RESET_N), .inc_i(wr_en), .clr_i(fq.FLUSH), .ptr_o(wr_ptr)
  );

  fq_ptr_ctr #(.W(PW)) u_rd_ptr (
    .clk_i (CLK), .rst_ni(RESET_N), .inc_i(rd_en), .clr_i(fq.FLUSH), .ptr_o(rd_ptr)
  );

  // Storage survives FLUSH; only reset clears it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr] <= '{pc: fq.IF_PC, ir: fq.IF_IR};
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (fq.IF_VALID && full && !fq.FLUSH) ovf_q <= 1'b1;
    end
  end

  assign COUNT      = count_q;
  assign OVF_STICKY = ovf_q;
endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed bench for otter_fetch_queue; scoreboard tracks accepted PCs in order.
module tb_otter_fetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef OTTER_FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] count;
  logic          ovf;

  otter_fetch_queue_if #(.XLEN(XLEN)) fq ();

  otter_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .fq        (fq),
    .COUNT     (count),
    .OVF_STICKY(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [XLEN-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;

  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return {pc[15:0], 16'h0013} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    fq.IF_VALID = v;
    fq.IF_PC    = pc;
    fq.IF_IR    = ir_of(pc);
    fq.ID_READY = rdy;
    fq.FLUSH    = fl;
  endtask

  task automatic drain();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 40 && count != '0; k++) tick();
    check("drain_done", 32'(count), 0);
  endtask

  // scoreboard: push on accepted fetch, pop and compare on accepted decode
  always @(negedge clk) begin
    if (!rst_n || fq.FLUSH) begin
      exp_q.delete();
    end else begin
      if (fq.IF_VALID && fq.IF_READY) exp_q.push_back(fq.IF_PC);
      if (fq.ID_VALID && fq.ID_READY) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL sb_underflow: observed pop of 0x%0h expected no entry", fq.ID_PC);
        end else begin
          logic [XLEN-1:0] e;
          e = exp_q.pop_front();
          check("pop_pc", fq.ID_PC, e);
          check("pop_ir", fq.ID_IR, ir_of(e));
        end
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int n0;
    int c0;
    int pre;

    // reset state
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #3;
    check("rst_if_ready", 32'(fq.IF_READY), 0);
    check("rst_id_valid", 32'(fq.ID_VALID), 0);
    check("rst_count",    32'(count), 0);
    check("rst_id_pc",    fq.ID_PC, 0);
    check("rst_id_ir",    fq.ID_IR, 0);
    check("rst_ovf",      32'(ovf), 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rel_if_ready", 32'(fq.IF_READY), 1);

    // fill to DEPTH with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
      tick();
      check("fill_count", 32'(count), i + 1);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("full_count",    32'(count), 4);
    check("full_if_ready", 32'(fq.IF_READY), 0);
    check("full_id_valid", 32'(fq.ID_VALID), 1);
    check("full_head_pc",  fq.ID_PC, 32'h0);

    // overflow sticky
    drive(1'b1, 32'h0EE0, 1'b0, 1'b0);
    #1;
    check("ovf_before", 32'(ovf), 0);
    tick();
    check("ovf_set",       32'(ovf), 1);
    check("ovf_count",     32'(count), 4);

    // drain in order, one per cycle
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_count", 32'(count), 3 - i);
    end
    check("drain_id_valid", 32'(fq.ID_VALID), 0);
    check("ovf_held",       32'(ovf), 1);

    // continuous streaming across pointer wraps
    n0 = n_pop;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
      tick();
      check("stream_count", 32'(count), BYP ? 0 : 1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check("stream_end_count", 32'(count), 0);
    check("stream_pops",      32'(n_pop - n0), 20);
    check("stream_sb_empty",  32'(exp_q.size()), 0);

    // two-cycle decode stall holds head 0x8
    pre = BYP ? 2 : 3;
    for (int i = 0; i < pre; i++) begin
      drive(1'b1, 32'(4 * i), 1'b1, 1'b0);
      tick();
    end
    c0 = int'(count);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'(4 * (pre + i)), 1'b0, 1'b0);
      tick();
      check("stall_head_pc", fq.ID_PC, 32'h8);
    end
    check("stall_count", 32'(count), 32'(c0 + 2));
    drain();

    // flush at COUNT=3 with both sides active
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    check("flush_pre_count", 32'(count), 3);
    drive(1'b1, 32'h4C, 1'b1, 1'b1);
    #1;
    check("flush_if_ready", 32'(fq.IF_READY), 0);
    check("flush_id_valid", 32'(fq.ID_VALID), 0);
    tick();
    check("flush_count", 32'(count), 0);
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    #1;
    check("post_flush_if_ready", 32'(fq.IF_READY), 1);
    tick();
    check("post_flush_count", 32'(count), 1);
    check("post_flush_head",  fq.ID_PC, 32'h100);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    check("post_flush_empty", 32'(count), 0);

    // asynchronous reset mid-stream
    drive(1'b1, 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h304, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_id_valid", 32'(fq.ID_VALID), 0);
    check("arst_count",    32'(count), 0);
    check("arst_id_pc",    fq.ID_PC, 0);
    check("arst_if_ready", 32'(fq.IF_READY), 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("arel_if_ready", 32'(fq.IF_READY), 1);
    check("arel_ovf",      32'(ovf), 0);

    // empty push with decode ready: 0 latency with bypass, 1 without
    drive(1'b1, 32'h200, 1'b1, 1'b0);
    #1;
    check("lat_id_valid", 32'(fq.ID_VALID), 32'(BYP));
    check("lat_id_pc",    fq.ID_PC, BYP ? 32'h200 : 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check("lat_count",     32'(count), BYP ? 0 : 1);
    check("lat_id_valid2", 32'(fq.ID_VALID), BYP ? 0 : 1);
    tick();
    check("lat_end_count", 32'(count), 0);
    check("final_sb_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
